logic_issue_ctrl: RTL and testbench

//   Issue/writeback controller for the logic functional unit. Accepts decoded

---
 rtl/logic_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_logic_issue_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_issue_ctrl.sv
// Issue/writeback controller for the logic functional unit: decode -> unit -> writeback.
// Define LOGIC_ISSUE_PERF_EN to build the saturating issued-op counter on perf_count.
module logic_issue_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [3:0]  LOGIC_OPC = 4'b0110,
  parameter int unsigned DEST_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_inst,
  input  logic [WIDTH-1:0]  in_value_c,
  input  logic [WIDTH-1:0]  in_value_a,
  input  logic [DEST_W-1:0] in_dest,
  output logic              fu_en,
  output logic [WIDTH-1:0]  fu_value_c,
  output logic [WIDTH-1:0]  fu_value_a,
  output logic [2:0]        fu_control,
  input  logic [WIDTH-1:0]  fu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_illegal,
  output logic [15:0]       perf_count
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              legal_q, legal_d;
  logic [WIDTH-1:0]  value_c_q, value_c_d;
  logic [WIDTH-1:0]  value_a_q, value_a_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [DEST_W-1:0] out_dest_q, out_dest_d;
  logic              illegal_q, illegal_d;
  logic              accept;
  logic              in_legal;
  logic              unused_inst;

  assign unused_inst = ^in_inst[11:3];

  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept   = in_valid & in_ready;
  assign in_legal = (in_inst[15:12] == LOGIC_OPC) & (in_inst[2:0] >= 3'b010);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    legal_d    = legal_q;
    value_c_d  = value_c_q;
    value_a_d  = value_a_q;
    dest_d     = dest_q;
    result_d   = result_q;
    out_dest_d = out_dest_q;
    illegal_d  = illegal_q;
    fu_en      = 1'b0;
    fu_value_c = '0;
    fu_value_a = '0;
    fu_control = 3'b000;
    out_valid  = 1'b0;

    // Operand latches are separate from the output registers, so a new op can be
    // accepted from DONE while the previous result is still being presented.
    if (accept) begin
      ctrl_d    = in_inst[2:0];
      legal_d   = in_legal;
      value_c_d = in_value_c;
      value_a_d = in_value_a;
      dest_d    = in_dest;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        fu_en = legal_q;
        if (legal_q) begin
          fu_value_c = value_c_q;
          fu_value_a = value_a_q;
          fu_control = ctrl_q;
        end
        result_d   = legal_q ? fu_result : '0;
        out_dest_d = dest_q;
        illegal_d  = ~legal_q;
        state_d    = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = accept ? StExec : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ctrl_q     <= 3'b000;
      legal_q    <= 1'b0;
      value_c_q  <= '0;
      value_a_q  <= '0;
      dest_q     <= '0;
      result_q   <= '0;
      out_dest_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      legal_q    <= legal_d;
      value_c_q  <= value_c_d;
      value_a_q  <= value_a_d;
      dest_q     <= dest_d;
      result_q   <= result_d;
      out_dest_q <= out_dest_d;
      illegal_q  <= illegal_d;
    end
  end

  assign out_result  = result_q;
  assign out_dest    = out_dest_q;
  assign out_illegal = illegal_q;

`ifdef LOGIC_ISSUE_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == StExec) && legal_q && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= 16'd0;
    else        perf_q <= perf_d;
  end

  assign perf_count = perf_q;
`else
  assign perf_count = 16'd0;
`endif

endmodule

// File: tb/tb_logic_issue_ctrl.sv
// Directed self-checking bench for logic_issue_ctrl with a behavioural stand-in logic unit.
module tb_logic_issue_ctrl;

`ifdef LOGIC_ISSUE_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_inst;
  logic [31:0] in_value_c, in_value_a;
  logic [3:0]  in_dest;
  logic        fu_en;
  logic [31:0] fu_value_c, fu_value_a;
  logic [2:0]  fu_control;
  logic [31:0] fu_result;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_dest;
  logic        out_illegal;
  logic [15:0] perf_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_perf = 0;

  logic_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_value_c(in_value_c), .in_value_a(in_value_a), .in_dest(in_dest),
    .fu_en(fu_en), .fu_value_c(fu_value_c), .fu_value_a(fu_value_a),
    .fu_control(fu_control), .fu_result(fu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_illegal(out_illegal), .perf_count(perf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in unit: garbage when disabled so an illegal op cannot leak a result.
  always_comb begin
    fu_result = 32'hDEAD_BEEF;
    if (fu_en) begin
      case (fu_control)
        3'b010:  fu_result = fu_value_c | fu_value_a;
        3'b101:  fu_result = fu_value_c & ~fu_value_a;
        default: fu_result = fu_value_c ^ fu_value_a;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] inst, input logic [31:0] c, input logic [31:0] a,
                       input logic [3:0] d);
    in_valid = 1'b1; in_inst = inst; in_value_c = c; in_value_a = a; in_dest = d;
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL reset_fu_en got %b exp 0", fu_en); end
    n_checks++; if (perf_count !== 16'd0) begin n_fail++; $display("FAIL reset_perf got %h exp 0", perf_count); end
    n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_out_result got %h exp 0", out_result); end
    n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal got %b exp 0", out_illegal); end
  endtask

  task automatic test_basic_or();
    out_ready = 1'b1;
    drive(16'h6002, 32'h0000_F0F0, 32'h0000_0F0F, 4'h5);
    step();
    in_valid = 1'b0;
    n_checks++; if (fu_en !== 1'b1) begin n_fail++; $display("FAIL basic_fu_en got %b exp 1", fu_en); end
    n_checks++; if (fu_control !== 3'b010) begin n_fail++; $display("FAIL basic_fu_control got %b exp 010", fu_control); end
    n_checks++; if (fu_value_c !== 32'h0000_F0F0) begin n_fail++; $display("FAIL basic_fu_c got %h exp 0000f0f0", fu_value_c); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_exec_ready got %b exp 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_exec_valid got %b exp 0", out_valid); end
    step();
    exp_perf++;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
    n_checks++; if (out_result !== 32'h0000_FFFF) begin n_fail++; $display("FAIL basic_result got %h exp 0000ffff", out_result); end
    n_checks++; if (out_dest !== 4'h5) begin n_fail++; $display("FAIL basic_dest got %h exp 5", out_dest); end
    n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL basic_illegal got %b exp 0", out_illegal); end
    n_checks++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL basic_done_fu_en got %b exp 0", fu_en); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready got %b exp 1", in_ready); end
    n_checks++; if (perf_count !== (PerfEn ? 16'(exp_perf) : 16'd0)) begin n_fail++; $display("FAIL basic_perf got %0d exp %0d", perf_count, PerfEn ? exp_perf : 0); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(16'h6005, 32'hFFFF_FFFF, 32'h0000_00FF, 4'h9);
    step();
    in_valid = 1'b0;
    step();
    exp_perf++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
      n_checks++; if (out_result !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL bp_result[%0d] got %h exp ffffff00", i, out_result); end
      n_checks++; if (out_dest !== 4'h9) begin n_fail++; $display("FAIL bp_dest[%0d] got %h exp 9", i, out_dest); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [15:0] insts [2];
    insts[0] = 16'h6000;
    insts[1] = 16'h1004;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(insts[i], 32'h1234_5678, 32'h0F0F_0F0F, 4'h2);
      step();
      in_valid = 1'b0;
      n_checks++; if (fu_en !== 1'b0) begin n_fail++; $display("FAIL ill_fu_en[%0d] got %b exp 0", i, fu_en); end
      n_checks++; if (fu_value_c !== 32'd0 || fu_control !== 3'd0) begin n_fail++; $display("FAIL ill_fu_quiet[%0d] got c=%h ctl=%b exp 0", i, fu_value_c, fu_control); end
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_valid[%0d] got %b exp 1", i, out_valid); end
      n_checks++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag[%0d] got %b exp 1", i, out_illegal); end
      n_checks++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL ill_result[%0d] got %h exp 0", i, out_result); end
      step();
    end
    n_checks++; if (perf_count !== (PerfEn ? 16'(exp_perf) : 16'd0)) begin n_fail++; $display("FAIL ill_perf got %0d exp %0d", perf_count, PerfEn ? exp_perf : 0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] t_inst [4];
    logic [31:0] t_c [4];
    logic [31:0] t_a [4];
    logic [31:0] t_exp [4];
    t_inst[0] = 16'h6002; t_c[0] = 32'h0000_00F0; t_a[0] = 32'h0000_000F; t_exp[0] = 32'h0000_00FF;
    t_inst[1] = 16'h6005; t_c[1] = 32'hFFFF_0000; t_a[1] = 32'hFF00_0000; t_exp[1] = 32'h00FF_0000;
    t_inst[2] = 16'h6002; t_c[2] = 32'h1234_0000; t_a[2] = 32'h0000_5678; t_exp[2] = 32'h1234_5678;
    t_inst[3] = 16'h6005; t_c[3] = 32'hAAAA_AAAA; t_a[3] = 32'h0F0F_0F0F; t_exp[3] = 32'hA0A0_A0A0;
    out_ready = 1'b1;
    drive(t_inst[0], t_c[0], t_a[0], 4'd3);
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (fu_en !== 1'b1) begin n_fail++; $display("FAIL b2b_fu_en[%0d] got %b exp 1", i, fu_en); end
      if (i < 3) drive(t_inst[i+1], t_c[i+1], t_a[i+1], 4'(i + 4));
      else in_valid = 1'b0;
      step();
      exp_perf++;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, out_valid); end
      n_checks++; if (out_result !== t_exp[i]) begin n_fail++; $display("FAIL b2b_result[%0d] got %h exp %h", i, out_result, t_exp[i]); end
      n_checks++; if (out_dest !== 4'(i + 3)) begin n_fail++; $display("FAIL b2b_dest[%0d] got %h exp %h", i, out_dest, 4'(i + 3)); end
      step();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid got %b exp 0", out_valid); end
    n_checks++; if (perf_count !== (PerfEn ? 16'(exp_perf) : 16'd0)) begin n_fail++; $display("FAIL b2b_perf got %0d exp %0d", perf_count, PerfEn ? exp_perf : 0); end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    drive(16'h6002, 32'h5555_0000, 32'h0000_AAAA, 4'hC);
    step();
    in_valid = 1'b0;
    n_checks++; if (fu_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_fu_en got %b exp 1", fu_en); end
    rst_n = 1'b0;
    exp_perf = 0;
    #1;
    n_checks++; if (fu_en !== 1'b0 || fu_value_c !== 32'd0) begin n_fail++; $display("FAIL rst_fu_clear got en=%b c=%h exp 0", fu_en, fu_value_c); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_result !== 32'd0 || out_dest !== 4'd0) begin n_fail++; $display("FAIL rst_out_clear got r=%h d=%h exp 0", out_result, out_dest); end
    n_checks++; if (perf_count !== 16'd0) begin n_fail++; $display("FAIL rst_perf got %0d exp 0", perf_count); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_valid[%0d] got %b exp 0", i, out_valid); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_value_c = '0; in_value_a = '0;
    in_dest = '0; out_ready = 1'b0;
    #2;
    test_reset();
    step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic_or();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
